// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared types, default timings and frame helpers for the DHT11 reader
package dht11_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START_LOW,
      ST_WAIT_RESP,
      ST_RESP_LOW,
      ST_RESP_HIGH,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_CHECK,
      ST_HOLDOFF
   } dht11_state_t;

   localparam int DEF_CLK_FREQ_HZ   = 100_000_000;
   localparam int DEF_START_LOW_US  = 18_000;
   localparam int DEF_TIMEOUT_US    = 200;
   localparam int DEF_BIT_THRESH_US = 40;
   localparam int DEF_HOLDOFF_US    = 1_000_000;

   localparam int CNT_W      = 20;
   localparam int FRAME_BITS = 40;

   // Byte positions inside the 40-bit frame, byte 4 arrives first.
   localparam int HUM_INT_IDX  = 4;
   localparam int HUM_DEC_IDX  = 3;
   localparam int TEMP_INT_IDX = 2;
   localparam int TEMP_DEC_IDX = 1;
   localparam int CSUM_IDX     = 0;

   function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame, input int idx);
      return frame[idx*8 +: 8];
   endfunction

   function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
      logic [7:0] sum;
      sum = frame_byte(frame, HUM_INT_IDX) + frame_byte(frame, HUM_DEC_IDX)
          + frame_byte(frame, TEMP_INT_IDX) + frame_byte(frame, TEMP_DEC_IDX);
      return sum == frame_byte(frame, CSUM_IDX);
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - prescaler producing a one-cycle pulse every DIV clocks
module us_tick_gen #(
   parameter int DIV = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] count;

   // clear preloads the terminal value so the first tick lands on the very next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= LAST;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/dht11_reader.sv
// rtl/dht11_reader.sv - DHT11 single-wire transaction engine: start pulse, response, 40-bit capture, checksum
module dht11_reader
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
   parameter int START_LOW_US  = DEF_START_LOW_US,
   parameter int TIMEOUT_US    = DEF_TIMEOUT_US,
   parameter int BIT_THRESH_US = DEF_BIT_THRESH_US,
   parameter int HOLDOFF_US    = DEF_HOLDOFF_US
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        dht_in,
   output logic        dht_oe,
   output logic [15:0] data,
   output logic [39:0] raw,
   output logic        data_valid,
   output logic        error,
   output logic        busy
);

   localparam int TICK_DIV = CLK_FREQ_HZ / 1_000_000;

   localparam logic [CNT_W-1:0] START_LOW_CNT = CNT_W'(START_LOW_US);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT   = CNT_W'(TIMEOUT_US);
   localparam logic [CNT_W-1:0] THRESH_CNT    = CNT_W'(BIT_THRESH_US);
   localparam logic [CNT_W-1:0] HOLDOFF_CNT   = CNT_W'(HOLDOFF_US);
   localparam logic [CNT_W-1:0] CNT_MAX       = '1;

   dht11_state_t          state;
   logic [CNT_W-1:0]      dur;
   logic [5:0]            bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic [2:0]            sync_q;
   logic                  line;
   logic                  line_q;
   logic                  rise;
   logic                  fall;
   logic                  timed_out;
   logic                  tick;
   logic                  tick_clear;

   // Stages 0/1 synchronize; stage 2 is the previous synchronized value for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[1:0], dht_in};
      end
   end

   assign line      = sync_q[1];
   assign line_q    = sync_q[2];
   assign rise      = line & ~line_q;
   assign fall      = ~line & line_q;
   assign timed_out = (dur >= TIMEOUT_CNT);
   assign busy      = (state != ST_IDLE);

   // Re-phasing the prescaler at the start of a high phase makes the bit width measurement exact in µs.
   assign tick_clear = (state == ST_BIT_LOW) && rise;

   us_tick_gen #(
      .DIV(TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(tick_clear),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         dur        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         data       <= '0;
         raw        <= '0;
         data_valid <= 1'b0;
         error      <= 1'b0;
         dht_oe     <= 1'b0;
      end else begin
         dht_oe <= (state == ST_START_LOW);
         if (tick && dur != CNT_MAX) begin
            dur <= dur + 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_START_LOW;
                  dur        <= '0;
                  data_valid <= 1'b0;
                  error      <= 1'b0;
               end
            end
            ST_START_LOW: begin
               if (dur >= START_LOW_CNT) begin
                  state <= ST_WAIT_RESP;
                  dur   <= '0;
               end
            end
            ST_WAIT_RESP: begin
               if (fall) begin
                  state <= ST_RESP_LOW;
                  dur   <= '0;
               end else if (timed_out) begin
                  error <= 1'b1;
                  state <= ST_HOLDOFF;
                  dur   <= '0;
               end
            end
            ST_RESP_LOW: begin
               if (rise) begin
                  state <= ST_RESP_HIGH;
                  dur   <= '0;
               end else if (timed_out) begin
                  error <= 1'b1;
                  state <= ST_HOLDOFF;
                  dur   <= '0;
               end
            end
            ST_RESP_HIGH: begin
               if (fall) begin
                  state   <= ST_BIT_LOW;
                  bit_cnt <= '0;
                  dur     <= '0;
               end else if (timed_out) begin
                  error <= 1'b1;
                  state <= ST_HOLDOFF;
                  dur   <= '0;
               end
            end
            ST_BIT_LOW: begin
               if (rise) begin
                  state <= ST_BIT_HIGH;
                  dur   <= '0;
               end else if (timed_out) begin
                  error <= 1'b1;
                  state <= ST_HOLDOFF;
                  dur   <= '0;
               end
            end
            ST_BIT_HIGH: begin
               if (fall) begin
                  shreg <= {shreg[FRAME_BITS-2:0], (dur > THRESH_CNT)};
                  dur   <= '0;
                  if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                     state <= ST_CHECK;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     state   <= ST_BIT_LOW;
                  end
               end else if (timed_out) begin
                  error <= 1'b1;
                  state <= ST_HOLDOFF;
                  dur   <= '0;
               end
            end
            ST_CHECK: begin
               if (checksum_ok(shreg)) begin
                  raw        <= shreg;
                  data       <= {frame_byte(shreg, HUM_INT_IDX), frame_byte(shreg, TEMP_INT_IDX)};
                  data_valid <= 1'b1;
               end else begin
                  error <= 1'b1;
               end
               state <= ST_HOLDOFF;
               dur   <= '0;
            end
            ST_HOLDOFF: begin
               if (dur >= HOLDOFF_CNT) begin
                  state <= ST_IDLE;
                  dur   <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               dur   <= '0;
            end
         endcase
      end
   end

endmodule
